// File: rtl/vsi_pkg.sv
// rtl/vsi_pkg.sv - shared types and defaults for the inverter-leg dead-time block
package vsi_pkg;

   localparam int VSI_DT_W = 8;

   typedef enum logic [2:0] {
      ST_OFF     = 3'd0,
      ST_DT_TO_H = 3'd1,
      ST_H_ON    = 3'd2,
      ST_DT_TO_L = 3'd3,
      ST_L_ON    = 3'd4,
      ST_FAULT   = 3'd5
   } vsi_state_e;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer with selectable reset value
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/vsi_deadtime.sv
// rtl/vsi_deadtime.sv - complementary gate drive for one bridge leg with dead time and fault latch
module vsi_deadtime
   import vsi_pkg::*;
#(
   parameter int DT_W = VSI_DT_W
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            pwm_in,
   input  logic [DT_W-1:0] dt,
   input  logic            fault_n,
   input  logic            clr_fault,
   output logic            gate_h,
   output logic            gate_l,
   output logic            fault_latched,
   output logic            dt_active
);

   vsi_state_e      state, state_nxt;
   logic [DT_W-1:0] cnt, cnt_nxt;
   logic [DT_W-1:0] dt_eff;
   logic            fault_s;

   sync2 #(.RST_VAL(1'b1)) u_fault_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (fault_n),
      .q     (fault_s)
   );

   // A zero dead time would let both gates switch in the same edge.
   assign dt_eff = (dt == '0) ? DT_W'(1) : dt;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = '0;
      if (!fault_s) begin
         state_nxt = ST_FAULT;
      end else begin
         case (state)
            ST_FAULT: begin
               if (clr_fault) state_nxt = ST_OFF;
            end
            ST_OFF: begin
               if (en) begin
                  state_nxt = pwm_in ? ST_DT_TO_H : ST_DT_TO_L;
                  cnt_nxt   = dt_eff;
               end
            end
            ST_DT_TO_H: begin
               if (!en) begin
                  state_nxt = ST_OFF;
               end else if (!pwm_in) begin
                  state_nxt = ST_DT_TO_L;
                  cnt_nxt   = dt_eff;
               end else if (cnt <= DT_W'(1)) begin
                  state_nxt = ST_H_ON;
               end else begin
                  cnt_nxt = cnt - DT_W'(1);
               end
            end
            ST_DT_TO_L: begin
               if (!en) begin
                  state_nxt = ST_OFF;
               end else if (pwm_in) begin
                  state_nxt = ST_DT_TO_H;
                  cnt_nxt   = dt_eff;
               end else if (cnt <= DT_W'(1)) begin
                  state_nxt = ST_L_ON;
               end else begin
                  cnt_nxt = cnt - DT_W'(1);
               end
            end
            ST_H_ON: begin
               if (!en) begin
                  state_nxt = ST_OFF;
               end else if (!pwm_in) begin
                  state_nxt = ST_DT_TO_L;
                  cnt_nxt   = dt_eff;
               end
            end
            ST_L_ON: begin
               if (!en) begin
                  state_nxt = ST_OFF;
               end else if (pwm_in) begin
                  state_nxt = ST_DT_TO_H;
                  cnt_nxt   = dt_eff;
               end
            end
            default: state_nxt = ST_OFF;
         endcase
      end
   end

   // Outputs are decoded from the next state so they register alongside it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= ST_OFF;
         cnt           <= '0;
         gate_h        <= 1'b0;
         gate_l        <= 1'b0;
         dt_active     <= 1'b0;
         fault_latched <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         gate_h        <= (state_nxt == ST_H_ON);
         gate_l        <= (state_nxt == ST_L_ON);
         dt_active     <= (state_nxt == ST_DT_TO_H) || (state_nxt == ST_DT_TO_L);
         fault_latched <= (state_nxt == ST_FAULT);
      end
   end

endmodule

// File: tb/tb_vsi_deadtime.sv
// tb/tb_vsi_deadtime.sv - self-checking bench for vsi_deadtime against a leg-level reference model
module tb_vsi_deadtime;

   logic       clk;
   logic       clk_run;
   logic       rst_n;
   logic       en;
   logic       pwm_in;
   logic [7:0] dt;
   logic       fault_n;
   logic       clr_fault;
   logic       gate_h;
   logic       gate_l;
   logic       fault_latched;
   logic       dt_active;

   int n_checks = 0;
   int n_errors = 0;

   vsi_deadtime #(.DT_W(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .en            (en),
      .pwm_in        (pwm_in),
      .dt            (dt),
      .fault_n       (fault_n),
      .clr_fault     (clr_fault),
      .gate_h        (gate_h),
      .gate_l        (gate_l),
      .fault_latched (fault_latched),
      .dt_active     (dt_active)
   );

   initial begin
      clk     = 1'b0;
      clk_run = 1'b1;
      forever begin
         #5;
         if (clk_run) clk = ~clk;
      end
   end

   // Leg model: which side conducts (-1 none), dead cycles still owed, fault flag.
   int m_side;
   int m_wait;
   int m_target;
   int m_load;
   bit m_fault;
   bit fh0, fh1;

   initial begin
      bit fs;
      m_side = -1; m_wait = 0; m_target = 0; m_load = 1; m_fault = 0; fh0 = 1; fh1 = 1;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_side = -1; m_wait = 0; m_fault = 0; fh0 = 1; fh1 = 1;
         end else begin
            fs  = fh1;
            fh1 = fh0;
            fh0 = fault_n;
            if (!fs) begin
               m_fault = 1; m_side = -1; m_wait = 0;
            end else if (m_fault) begin
               if (clr_fault) m_fault = 0;
            end else if (!en) begin
               m_side = -1; m_wait = 0;
            end else if (m_wait > 0) begin
               if (int'(pwm_in) != m_target) begin
                  m_target = int'(pwm_in);
                  m_load   = (dt == 0) ? 1 : int'(dt);
                  m_wait   = m_load;
               end else if (m_wait == 1) begin
                  m_side = m_target; m_wait = 0;
               end else begin
                  m_wait = m_wait - 1;
               end
            end else if (m_side != int'(pwm_in)) begin
               m_side   = -1;
               m_target = int'(pwm_in);
               m_load   = (dt == 0) ? 1 : int'(dt);
               m_wait   = m_load;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         if (n_errors <= 30)
            $display("FAIL %s at %0t: {h,l,dt,f} got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Every-cycle comparison against the model plus the gate-safety rules.
   initial begin
      logic [3:0] exp_o;
      bit prev_h, prev_l;
      int low_run;
      prev_h = 0; prev_l = 0; low_run = 0;
      forever begin
         @(posedge clk);
         #1;
         if (!rst_n) begin
            prev_h = 0; prev_l = 0; low_run = 0;
         end else begin
            exp_o = {m_side == 1, m_side == 0, m_wait > 0, m_fault};
            chk("model", {gate_h, gate_l, dt_active, fault_latched}, exp_o);
            chk("overlap", {3'b000, gate_h & gate_l}, 4'b0000);
            if ((gate_h && !prev_h) || (gate_l && !prev_l)) begin
               n_checks++;
               if (low_run < m_load) begin
                  n_errors++;
                  if (n_errors <= 30)
                     $display("FAIL rise_deadtime at %0t: low cycles %0d required %0d", $time, low_run, m_load);
               end
            end
            low_run = (!gate_h && !gate_l) ? low_run + 1 : 0;
            prev_h  = gate_h;
            prev_l  = gate_l;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      int fault_cnt;
      rst_n = 1'b0; en = 1'b0; pwm_in = 1'b0; dt = 8'd5; fault_n = 1'b1; clr_fault = 1'b0;
      tick(3);
      chk("reset_state", {gate_h, gate_l, dt_active, fault_latched}, 4'b0000);
      rst_n = 1'b1;

      // basic dead time, dt=5: enter L_ON then toggle every 20 cycles
      en = 1'b1;
      tick(1);
      chk("enter_dt_l", {gate_h, gate_l, dt_active, fault_latched}, 4'b0010);
      tick(5);
      chk("l_on", {gate_h, gate_l, dt_active, fault_latched}, 4'b0100);
      for (int k = 0; k < 4; k++) begin
         pwm_in = ~pwm_in;
         tick(1);
         chk("dt5_first", {gate_h, gate_l, dt_active, fault_latched}, 4'b0010);
         tick(4);
         chk("dt5_last", {gate_h, gate_l, dt_active, fault_latched}, 4'b0010);
         tick(1);
         chk("dt5_rise", {gate_h, gate_l, dt_active, fault_latched}, pwm_in ? 4'b1000 : 4'b0100);
         tick(14);
      end

      // minimum dead time: dt=0 behaves as one cycle
      dt = 8'd0; pwm_in = 1'b1;
      tick(1);
      chk("dt0_gap", {gate_h, gate_l, dt_active, fault_latched}, 4'b0010);
      tick(1);
      chk("dt0_rise", {gate_h, gate_l, dt_active, fault_latched}, 4'b1000);

      // reversal during dead time, dt=8
      dt = 8'd8;
      tick(3);
      pwm_in = 1'b0;
      tick(1);
      chk("rev_enter", {gate_h, gate_l, dt_active, fault_latched}, 4'b0010);
      tick(2);
      pwm_in = 1'b1;
      tick(1);
      chk("rev_reload", {gate_h, gate_l, dt_active, fault_latched}, 4'b0010);
      tick(7);
      chk("rev_hold", {gate_h, gate_l, dt_active, fault_latched}, 4'b0010);
      tick(1);
      chk("rev_rise", {gate_h, gate_l, dt_active, fault_latched}, 4'b1000);

      // one-cycle fault pulse in H_ON
      tick(2);
      fault_n = 1'b0;
      tick(1);
      fault_n = 1'b1;
      tick(1);
      chk("fault_sync_delay", {gate_h, gate_l, dt_active, fault_latched}, 4'b1000);
      tick(1);
      chk("fault_latch", {gate_h, gate_l, dt_active, fault_latched}, 4'b0001);
      fault_n = 1'b0;
      tick(3);
      clr_fault = 1'b1;
      tick(1);
      clr_fault = 1'b0;
      chk("clr_ignored", {gate_h, gate_l, dt_active, fault_latched}, 4'b0001);
      fault_n = 1'b1;
      tick(3);
      clr_fault = 1'b1;
      tick(1);
      clr_fault = 1'b0;
      chk("clr_to_off", {gate_h, gate_l, dt_active, fault_latched}, 4'b0000);
      tick(1);
      chk("post_fault_dt", {gate_h, gate_l, dt_active, fault_latched}, 4'b0010);
      tick(8);
      chk("post_fault_h", {gate_h, gate_l, dt_active, fault_latched}, 4'b1000);

      // enable drop mid DT_TO_H
      pwm_in = 1'b0;
      tick(9);
      chk("en_l_on", {gate_h, gate_l, dt_active, fault_latched}, 4'b0100);
      pwm_in = 1'b1;
      tick(3);
      en = 1'b0;
      tick(1);
      chk("en_off", {gate_h, gate_l, dt_active, fault_latched}, 4'b0000);
      tick(10);
      chk("en_no_pulse", {gate_h, gate_l, dt_active, fault_latched}, 4'b0000);
      en = 1'b1; pwm_in = 1'b0;
      tick(9);
      chk("reen_l_on", {gate_h, gate_l, dt_active, fault_latched}, 4'b0100);

      // reset with the clock stopped while in L_ON
      @(negedge clk);
      clk_run = 1'b0;
      #20;
      rst_n = 1'b0;
      #1;
      chk("async_reset", {gate_h, gate_l, dt_active, fault_latched}, 4'b0000);
      #10;
      rst_n = 1'b1;
      #4;
      clk_run = 1'b1;
      tick(2);

      // randomized run
      fault_cnt = 0;
      dt = 8'd3;
      for (int c = 0; c < 20000; c++) begin
         tick(1);
         if ($urandom_range(0, 11) == 0) pwm_in = ~pwm_in;
         if ($urandom_range(0, 49) == 0) dt = 8'($urandom_range(0, 10));
         en = ($urandom_range(0, 199) != 0);
         clr_fault = ($urandom_range(0, 15) == 0);
         if (fault_cnt > 0) begin
            fault_n = 1'b0;
            fault_cnt--;
         end else begin
            fault_n = 1'b1;
            if ($urandom_range(0, 399) == 0) fault_cnt = $urandom_range(1, 4);
         end
      end
      tick(2);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
